// File: rtl/aes_pkg.sv
// Shared AES definitions: cipher op encoding, GF(2^8) xtime helpers and
// column extract/insert for the k = 4*row + col state byte layout.
package aes_pkg;

  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

  function automatic logic [7:0] aes_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] b);
    return aes_mul2(aes_mul2(b));
  endfunction

  // Column word packs row r into bits [8r+:8].
  function automatic logic [31:0] aes_col_get(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] col;
    col = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col[8*r +: 8] = s[8*(4*r + 32'(c)) +: 8];
    end
    return col;
  endfunction

  function automatic logic [127:0] aes_col_set(input logic [127:0] s, input logic [1:0] c,
                                                input logic [31:0] col);
    logic [127:0] res;
    res = s;
    for (int unsigned r = 0; r < 4; r++) begin
      res[8*(4*r + 32'(c)) +: 8] = col[8*r +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_mix_single_column.sv
// Combinational single-column (Inv)MixColumns; the inverse path reuses the
// forward network after a 04-multiply pre-conditioning step.
module aes_inv_mix_single_column
  import aes_pkg::*;
(
  input  ciph_op_e    op,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [7:0] a [4];
  logic [7:0] b [4];
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] t;

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      a[r] = data[8*r +: 8];
    end
    x = aes_mul4(a[0] ^ a[2]);
    y = aes_mul4(a[1] ^ a[3]);
    if (op == CIPH_FWD) begin
      b = a;
    end else begin
      b[0] = a[0] ^ x;
      b[1] = a[1] ^ y;
      b[2] = a[2] ^ x;
      b[3] = a[3] ^ y;
    end
    t = b[0] ^ b[1] ^ b[2] ^ b[3];
    result = '0;
    // 02*b_r ^ 03*b_(r+1) ^ b_(r+2) ^ b_(r+3) folded around the column parity t
    for (int unsigned r = 0; r < 4; r++) begin
      result[8*r +: 8] = b[r] ^ t ^ aes_mul2(b[r] ^ b[(r + 1) % 4]);
    end
  end

endmodule

// File: rtl/aes_inv_mix_columns_iter.sv
// Column-serial InvMixColumns engine with valid/ready on both sides.
// Optional AES_INV_MC_FWD_EN adds a per-block forward/inverse op select.
module aes_inv_mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [1:0]   op_i,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e       state;
  logic [127:0] state_reg;
  logic [1:0]   col_cnt;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  ciph_op_e     op_sel;

`ifdef AES_INV_MC_FWD_EN
  ciph_op_e op_q;
  assign op_sel = op_q;
`else
  logic unused_op;
  assign unused_op = ^op_i;
  assign op_sel    = CIPH_INV;
`endif

  assign col_in = aes_col_get(state_reg, col_cnt);
  assign data_o = state_reg;

  aes_inv_mix_single_column u_column (
    .op     (op_sel),
    .data   (col_in),
    .result (col_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      state_reg   <= '0;
      col_cnt     <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef AES_INV_MC_FWD_EN
      op_q        <= CIPH_INV;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            state_reg  <= data_i;
            col_cnt    <= '0;
            state      <= BUSY;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
`ifdef AES_INV_MC_FWD_EN
            // Anything but CIPH_FWD collapses to the inverse transform.
            op_q       <= (op_i == CIPH_FWD) ? CIPH_FWD : CIPH_INV;
`endif
          end
        end
        BUSY: begin
          state_reg <= aes_col_set(state_reg, col_cnt, col_out);
          col_cnt   <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          col_cnt     <= '0;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_inv_mix_columns_iter.md
# aes_inv_mix_columns_iter

Column-serial InvMixColumns engine for the AES decryption datapath. It processes one 32-bit state column per cycle through a single shared column unit, which trades area for latency. A valid/ready handshake on both sides lets the cipher core stall it freely. It is the inverse-direction counterpart to the combinational all-column MixColumns stage, built so the decryption round can run area-reduced.

## Interface
Parameters:
- none; the state width is fixed at 128 bits and there are 4 columns.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; one clock, asynchronous, active-high.
- in_valid_i  input  1  data_i/op_i valid.
- in_ready_o  output  1  block accepts new state.
- op_i  input  2  ciph_op_e; CIPH_FWD=2'b01, CIPH_INV=2'b10.
- data_i  input  128  input state; byte k = data_i[8k+:8], k = 4*row + col.
- out_valid_o  output  1  data_o valid.
- out_ready_i  input  1  consumer accepts data_o.
- data_o  output  128  result state, same byte layout as data_i.
- busy_o  output  1  high in BUSY or DONE.

## Operation
- Column c = bytes {c, 4+c, 8+c, 12+c} (row 0..3). Columns are processed in the order 0,1,2,3 and written back in place into the 128-bit state register.
- Inverse column transform: out_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), with row indices mod 4 and multiplication in GF(2^8) mod 0x11B.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, capture data_i into the state register, latch op_i, set col_cnt=0, and go to BUSY.
  - BUSY: each cycle, transform column col_cnt and increment col_cnt (2-bit). When col_cnt==3, go to DONE.
  - DONE: out_valid_o=1. data_o is held stable while out_ready_i=0. On out_ready_i=1, go to IDLE.
- in_valid_i during BUSY or DONE is ignored (in_ready_o=0). data_i and op_i are sampled only at the accept edge.
- op_i values other than CIPH_FWD are treated as CIPH_INV. This is the safe default, and 2'b00/2'b11 are included.
- data_o is driven from the state register at all times; it is meaningful only while out_valid_o=1.

## Timing
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, busy_o=0, data_o=128'h0, col_cnt=0.
- Latency: accept on edge E0; columns 0..3 are written on edges E1..E4; out_valid_o=1 from E4. The output transfer occurs at the first edge with out_ready_i=1 (at earliest E5). in_ready_o=1 again after that edge.
- Minimum initiation interval is 6 cycles. No overlap between consecutive blocks.
- Reset asserted mid-operation (BUSY or DONE) immediately returns the block to IDLE and zeroes the state register. The partial result is discarded and no out_valid_o pulse occurs.
- out_ready_i asserted outside DONE has no effect.

## Configuration
- AES_INV_MC_FWD_EN:
  - Defined: the latched op selects per block. CIPH_FWD applies the forward transform 02·a_r ^ 03·a_(r+1) ^ a_(r+2) ^ a_(r+3). Any other op value applies the inverse transform.
  - Undefined: op_i is ignored, the op latch is not built, and every block is inverse-transformed.
- Latency and handshake are identical in both builds.

## Structure
- aes_pkg holds:
  - ciph_op_e;
  - GF helpers aes_mul2/aes_mul4 (xtime-based);
  - a column extract/insert helper for the k = 4*row + col layout.
- The FSM state type is local to the block. States are encoded IDLE=2'b00, BUSY=2'b01, DONE=2'b10. Illegal encodings go to IDLE.
- One sub-module, aes_inv_mix_single_column: a combinational 32-bit column transform with op input.
  - Inverse path computed as pre-multiply (a_r ^= 04·(a_r ^ a_(r+2))) followed by the forward MixColumns network, sharing xtime logic.

## Test plan
- Inverse, single column: column 0 = 8e,4d,a1,bc and other columns 01,01,01,01 -> column 0 = db,13,53,45, other columns unchanged. out_valid_o rises 4 cycles after accept.
- Inverse, all columns: columns 9f,dc,58,9d / 01,01,01,01 / 4d,7e,bd,f8 / d5,d5,d7,d6 -> f2,0a,22,5c / 01,01,01,01 / 2d,26,31,4c / d4,d4,d4,d5.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE. Required: data_o stable, in_ready_o=0, second in_valid_i ignored. Release -> one transfer, then in_ready_o=1.
- Reset at E2 of a block: outputs return to reset values asynchronously, and no out_valid_o follows. The next block then gives the correct result.
- With AES_INV_MC_FWD_EN, op_i=CIPH_FWD on db,13,53,45 -> 8e,4d,a1,bc. Without the macro, the same stimulus -> inverse result.
- op_i=2'b11 on 8e,4d,a1,bc -> db,13,53,45 (inverse default), in both builds.
